// File: rtl/lamp_sequencer.sv
// Red/green/yellow lamp scheduler with a latched pedestrian walk phase and a
// flashing-yellow override. Every output comes straight from a register.
module lamp_sequencer #(
    parameter int RED_CYC = 8,
    parameter int GRN_CYC = 6,
    parameter int YEL_CYC = 2,
    parameter int PED_CYC = 4,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             ped_req,
    input  logic             flash,
    output logic [2:0]       light,
    output logic             ped_ack,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] timer
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RED    = 3'd1,
        S_PED    = 3'd2,
        S_GREEN  = 3'd3,
        S_YELLOW = 3'd4,
        S_FLASH  = 3'd5
    } state_e;

    // Reload values are the phase length minus one so a phase ends on timer == 0.
    localparam logic [CNT_W-1:0] RED_LD  = CNT_W'(RED_CYC - 1);
    localparam logic [CNT_W-1:0] GRN_LD  = CNT_W'(GRN_CYC - 1);
    localparam logic [CNT_W-1:0] YEL_LD  = CNT_W'(YEL_CYC - 1);
    localparam logic [CNT_W-1:0] PED_LD  = CNT_W'(PED_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             ped_pending_q, ped_pending_d;
    logic [2:0]       light_q, light_d;
    logic [1:0]       phase_q, phase_d;
    logic             ped_ack_q, ped_ack_d;
    logic             expired_s;

    assign expired_s = (timer_q == CNT_ZERO);

    // Next-state, phase timer and pedestrian latch; flash overrides every state.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        ped_pending_d = ped_pending_q;

        if (ped_req && (state_q != S_PED)) begin
            ped_pending_d = 1'b1;
        end else begin
            ped_pending_d = ped_pending_q;
        end

        if (flash) begin
            state_d = S_FLASH;
            timer_d = CNT_ZERO;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_d = S_RED;
                        timer_d = RED_LD;
                    end else begin
                        state_d = S_IDLE;
                        timer_d = CNT_ZERO;
                    end
                end
                S_RED: begin
                    if (!expired_s) begin
                        timer_d = timer_q - CNT_ONE;
                    end else if (ped_pending_q || ped_req) begin
                        state_d       = S_PED;
                        timer_d       = PED_LD;
                        ped_pending_d = 1'b0;
                    end else if (enable) begin
                        state_d = S_GREEN;
                        timer_d = GRN_LD;
                    end else begin
                        state_d = S_IDLE;
                        timer_d = CNT_ZERO;
                    end
                end
                S_PED: begin
                    if (expired_s) begin
                        state_d = S_GREEN;
                        timer_d = GRN_LD;
                    end else begin
                        timer_d = timer_q - CNT_ONE;
                    end
                end
                S_GREEN: begin
                    if (expired_s) begin
                        state_d = S_YELLOW;
                        timer_d = YEL_LD;
                    end else begin
                        timer_d = timer_q - CNT_ONE;
                    end
                end
                S_YELLOW: begin
                    if (expired_s) begin
                        state_d = S_RED;
                        timer_d = RED_LD;
                    end else begin
                        timer_d = timer_q - CNT_ONE;
                    end
                end
                S_FLASH: begin
                    // Leaving flash always restarts from a complete red phase.
                    state_d = S_RED;
                    timer_d = RED_LD;
                end
                default: begin
                    state_d = S_IDLE;
                    timer_d = CNT_ZERO;
                end
            endcase
        end
    end

    // Output decode from the next state so outputs move on the same edge as the state.
    always_comb begin
        light_d   = 3'b100;
        phase_d   = 2'b00;
        ped_ack_d = 1'b0;
        case (state_d)
            S_IDLE, S_RED: begin
                light_d = 3'b100;
                phase_d = 2'b00;
            end
            S_PED: begin
                light_d   = 3'b100;
                ped_ack_d = 1'b1;
            end
            S_GREEN: begin
                light_d = 3'b010;
                phase_d = 2'b01;
            end
            S_YELLOW: begin
                light_d = 3'b001;
                phase_d = 2'b10;
            end
            S_FLASH: begin
                phase_d = 2'b11;
                if (state_q == S_FLASH) begin
                    light_d = light_q ^ 3'b001;
                end else begin
                    light_d = 3'b001;
                end
            end
            default: begin
                light_d = 3'b100;
                phase_d = 2'b00;
            end
        endcase
    end

    // State, timer, pedestrian latch and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            timer_q       <= CNT_ZERO;
            ped_pending_q <= 1'b0;
            light_q       <= 3'b100;
            phase_q       <= 2'b00;
            ped_ack_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            ped_pending_q <= ped_pending_d;
            light_q       <= light_d;
            phase_q       <= phase_d;
            ped_ack_q     <= ped_ack_d;
        end
    end

    assign light   = light_q;
    assign phase   = phase_q;
    assign ped_ack = ped_ack_q;
    assign timer   = timer_q;

endmodule

// File: tb/tb_lamp_sequencer.sv
// Bench for lamp_sequencer: three parameter sets driven in lockstep and compared
// every cycle against a remaining-clocks model of the lamp schedule.
module tb_lamp_sequencer;

    logic clk, rst_n, enable, ped_req, flash;
    logic [2:0] light0, light1, light2;
    logic       ack0, ack1, ack2;
    logic [1:0] phase0, phase1, phase2;
    logic [3:0] timer0, timer1, timer2;

    lamp_sequencer u0 (.clk(clk), .rst_n(rst_n), .enable(enable), .ped_req(ped_req), .flash(flash),
                       .light(light0), .ped_ack(ack0), .phase(phase0), .timer(timer0));
    lamp_sequencer #(.RED_CYC(1), .GRN_CYC(1), .YEL_CYC(1), .PED_CYC(1), .CNT_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ped_req(ped_req), .flash(flash),
        .light(light1), .ped_ack(ack1), .phase(phase1), .timer(timer1));
    lamp_sequencer #(.RED_CYC(16), .CNT_W(4)) u2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ped_req(ped_req), .flash(flash),
        .light(light2), .ped_ack(ack2), .phase(phase2), .timer(timer2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model modes: what the lamp is doing, and how many clocks of it remain.
    localparam int M_IDLE = 0, M_RED = 1, M_WALK = 2, M_GREEN = 3, M_YELLOW = 4, M_FLASH = 5;
    typedef struct { int mode; int left; bit pend; bit lit; } mdl_t;

    int   red_len [3] = '{8, 1, 16};
    int   grn_len [3] = '{6, 1, 6};
    int   yel_len [3] = '{2, 1, 2};
    int   ped_len [3] = '{4, 1, 4};
    mdl_t m [3];
    int   chk_n  = 0;
    int   pass_n = 0;
    int   cyc    = 0;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.mode = M_IDLE; r.left = 1; r.pend = 1'b0; r.lit = 1'b0;
        return r;
    endfunction

    function automatic mdl_t step(mdl_t c, bit en, bit pr, bit fl, int k);
        mdl_t n = c;
        bool_last: begin end
        if (pr && c.mode != M_WALK) n.pend = 1'b1;
        if (fl) begin
            n.lit  = (c.mode == M_FLASH) ? !c.lit : 1'b1;
            n.mode = M_FLASH;
            n.left = 1;
        end else if (c.mode == M_FLASH) begin
            n.mode = M_RED; n.left = red_len[k];
        end else if (c.mode == M_IDLE) begin
            if (en) begin n.mode = M_RED; n.left = red_len[k]; end
        end else if (c.left > 1) begin
            n.left = c.left - 1;
        end else if (c.mode == M_RED) begin
            if (c.pend || pr) begin n.mode = M_WALK; n.left = ped_len[k]; n.pend = 1'b0; end
            else if (en) begin n.mode = M_GREEN; n.left = grn_len[k]; end
            else begin n.mode = M_IDLE; n.left = 1; end
        end else if (c.mode == M_WALK) begin
            n.mode = M_GREEN; n.left = grn_len[k];
        end else if (c.mode == M_GREEN) begin
            n.mode = M_YELLOW; n.left = yel_len[k];
        end else begin
            n.mode = M_RED; n.left = red_len[k];
        end
        return n;
    endfunction

    function automatic logic [9:0] exp_out(mdl_t c);
        logic [2:0] l;
        logic [1:0] p;
        case (c.mode)
            M_GREEN:  begin l = 3'b010; p = 2'b01; end
            M_YELLOW: begin l = 3'b001; p = 2'b10; end
            M_FLASH:  begin l = c.lit ? 3'b001 : 3'b000; p = 2'b11; end
            default:  begin l = 3'b100; p = 2'b00; end
        endcase
        return {l, (c.mode == M_WALK), p, 4'(c.left - 1)};
    endfunction

    function automatic logic [29:0] exp_all();
        return {exp_out(m[0]), exp_out(m[1]), exp_out(m[2])};
    endfunction

    function automatic logic [29:0] obs_all();
        return {light0, ack0, phase0, timer0, light1, ack1, phase1, timer1,
                light2, ack2, phase2, timer2};
    endfunction

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) m[k] = mdl_reset();
            else        m[k] = step(m[k], enable, ped_req, flash, k);
        end
        cyc++;
        #1;
    endtask

    task automatic wait_m0(int mode, int left, string name);
        int n = 0;
        while (!(m[0].mode == mode && m[0].left == left) && n < 64) begin
            tick();
            n++;
        end
        chk_n++;
        if (!(m[0].mode == mode && m[0].left == left))
            $display("FAIL wait_%s: model mode %0d left %0d, required mode %0d left %0d", name, m[0].mode, m[0].left, mode, left);
        else pass_n++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; ped_req = 1'b0; flash = 1'b0;
        for (int k = 0; k < 3; k++) m[k] = mdl_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_n++;
            if (obs_all() !== exp_all()) $display("FAIL reset cyc %0d: got %h expected %h", cyc, obs_all(), exp_all());
            else pass_n++;
        end
        chk_n++;
        if ({light0, ack0, phase0, timer0} !== 10'b100_0_00_0000)
            $display("FAIL reset_value: got %b expected 1000000000", {light0, ack0, phase0, timer0});
        else pass_n++;
        rst_n = 1'b1;
    endtask

    task automatic test_free_run();
        tick();
        enable = 1'b1;
        tick();
        chk_n++;
        if ({light0, timer0, light2, timer2} !== {3'b100, 4'd7, 3'b100, 4'd15})
            $display("FAIL free_run_start: got %h expected %h", {light0, timer0, light2, timer2}, {3'b100, 4'd7, 3'b100, 4'd15});
        else pass_n++;
        for (int i = 0; i < 48; i++) begin
            tick();
            chk_n++;
            if (obs_all() !== exp_all()) $display("FAIL free_run cyc %0d: got %h expected %h", cyc, obs_all(), exp_all());
            else pass_n++;
        end
    endtask

    task automatic test_ped();
        int  acks = 0;
        bit  second = 1'b0;
        wait_m0(M_GREEN, 6, "ped_green");
        ped_req = 1'b1;
        tick();
        ped_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ack0) acks++;
            if (ack0 && !second) begin ped_req = 1'b1; second = 1'b1; end
            tick();
            ped_req = 1'b0;
            chk_n++;
            if (obs_all() !== exp_all()) $display("FAIL ped cyc %0d: got %h expected %h", cyc, obs_all(), exp_all());
            else pass_n++;
        end
        chk_n++;
        if (acks !== 4) $display("FAIL ped_single_service: got %0d walk clocks expected 4", acks);
        else pass_n++;
        wait_m0(M_RED, 1, "red_expiry");
        ped_req = 1'b1;
        tick();
        ped_req = 1'b0;
        chk_n++;
        if ({ack0, light0, timer0} !== {1'b1, 3'b100, 4'd3})
            $display("FAIL ped_on_expiry: got %b expected 11000011", {ack0, light0, timer0});
        else pass_n++;
    endtask

    task automatic test_flash();
        wait_m0(M_GREEN, 4, "flash_green");
        flash = 1'b1;
        tick();
        chk_n++;
        if ({light0, phase0, timer0} !== {3'b001, 2'b11, 4'd0})
            $display("FAIL flash_first: got %b expected 001110000", {light0, phase0, timer0});
        else pass_n++;
        tick();
        chk_n++;
        if (light0 !== 3'b000) $display("FAIL flash_toggle: got %b expected 000", light0);
        else pass_n++;
        for (int i = 0; i < 3; i++) begin
            ped_req = (i == 1);
            tick();
            chk_n++;
            if (obs_all() !== exp_all()) $display("FAIL flash cyc %0d: got %h expected %h", cyc, obs_all(), exp_all());
            else pass_n++;
        end
        ped_req = 1'b0;
        flash = 1'b0;
        tick();
        chk_n++;
        if ({light0, phase0, timer0} !== {3'b100, 2'b00, 4'd7})
            $display("FAIL flash_exit: got %b expected 100000111", {light0, phase0, timer0});
        else pass_n++;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk_n++;
            if (obs_all() !== exp_all()) $display("FAIL flash_red cyc %0d: got %h expected %h", cyc, obs_all(), exp_all());
            else pass_n++;
        end
        tick();
        chk_n++;
        if (ack0 !== 1'b1) $display("FAIL flash_ped_kept: got ped_ack %b expected 1", ack0);
        else pass_n++;
    endtask

    task automatic test_enable_drop();
        wait_m0(M_GREEN, 5, "drop_green");
        enable = 1'b0;
        for (int i = 0; i < 17; i++) begin
            tick();
            chk_n++;
            if (obs_all() !== exp_all()) $display("FAIL enable_drop cyc %0d: got %h expected %h", cyc, obs_all(), exp_all());
            else pass_n++;
        end
        chk_n++;
        if ({light0, phase0, timer0} !== {3'b100, 2'b00, 4'd0})
            $display("FAIL idle_hold: got %b expected 100000000", {light0, phase0, timer0});
        else pass_n++;
        enable = 1'b1;
        tick();
        chk_n++;
        if ({light0, timer0} !== {3'b100, 4'd7}) $display("FAIL re_enable: got %b expected 1000111", {light0, timer0});
        else pass_n++;
    endtask

    task automatic test_async_reset();
        wait_m0(M_GREEN, 3, "reset_green");
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) m[k] = mdl_reset();
        chk_n++;
        if ({light0, ack0, phase0, timer0} !== 10'b100_0_00_0000)
            $display("FAIL async_reset: got %b expected 1000000000", {light0, ack0, phase0, timer0});
        else pass_n++;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk_n++;
            if (obs_all() !== exp_all()) $display("FAIL post_reset cyc %0d: got %h expected %h", cyc, obs_all(), exp_all());
            else pass_n++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            enable  = ($urandom_range(0, 9) != 0);
            ped_req = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 29) == 0) flash = !flash;
            tick();
            chk_n++;
            if (obs_all() !== exp_all()) $display("FAIL random cyc %0d: got %h expected %h", cyc, obs_all(), exp_all());
            else pass_n++;
        end
        flash = 1'b0;
        ped_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_ped();
        test_flash();
        test_enable_drop();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_n, chk_n);
        $finish;
    end

endmodule

// File: doc/lamp_sequencer.md
# lamp_sequencer

Scheduler that drives the rgy lamp bus (`light[2:0]`) through a red, green and yellow cycle with parameterised phase durations. It adds a latched pedestrian request serviced by an extended-red walk phase, and a flash override. It sits between a lamp output (or a `cyclic_lamp`-style display) and the supervisory control inputs. All outputs are registered (Moore).

## Interface
Parameters:
- `RED_CYC`, 8: red phase length in clocks (1..2^CNT_W).
- `GRN_CYC`, 6: green phase length in clocks (1..2^CNT_W).
- `YEL_CYC`, 2: yellow phase length in clocks (1..2^CNT_W).
- `PED_CYC`, 4: pedestrian walk (held red) length in clocks (1..2^CNT_W).
- `CNT_W`, 4: phase timer width.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run the cycle; when low, the block parks in IDLE at the end of the red phase.
- `ped_req`  in  1  pedestrian request; level-sampled each clock.
- `flash`  in  1  override to flashing yellow; highest priority.
- `light`  out  3  lamp drive, [2]=red, [1]=green, [0]=yellow; exactly one bit is high, or none in the flash off-beat.
- `ped_ack`  out  1  high for the whole PED phase.
- `phase`  out  2  00 red (IDLE/RED/PED), 01 green, 10 yellow, 11 flash.
- `timer`  out  CNT_W  remaining clocks in the current phase minus 1.

## Operation
- States: IDLE, RED, PED, GREEN, YELLOW, FLASH.
- Reset (async, no clock needed): state=IDLE, `light`=100, `ped_ack`=0, `phase`=00, `timer`=0, `ped_pending`=0.
- On phase entry, load `timer` with `<PHASE>_CYC`-1. Decrement each clock; the phase ends on the clock where `timer`==0. Each phase therefore lasts exactly `<PHASE>_CYC` clocks.
- IDLE: `light`=100. If `enable`=1 → RED.
- RED: `light`=100. At expiry:
  - `ped_pending` or `ped_req`=1 → PED; clear `ped_pending` on entry.
  - Else `enable`=1 → GREEN.
  - Else → IDLE.
- PED: `light`=100, `ped_ack`=1. At expiry → GREEN, regardless of `enable`.
- GREEN: `light`=010. At expiry → YELLOW.
- YELLOW: `light`=001. At expiry → RED.
- `ped_pending`: set on any clock with `ped_req`=1 while state≠PED. Requests during PED are dropped. Repeated requests collapse into one service.
- FLASH:
  - `flash`=1 at any clock edge, from any state → FLASH.
  - First FLASH clock `light`=001, then it toggles 000/001 every clock.
  - `timer` is held at 0. `ped_pending` is preserved and still set by `ped_req`.
  - `flash`=0 → RED with full reload (safe restart), even if `enable`=0.
- `enable`=0 mid-cycle does not cut the current phase short. The cycle proceeds GREEN→YELLOW→RED, then IDLE.

## Timing
- `light`, `phase`, `ped_ack` and `timer` change on the same edge as the state register. No combinational path from inputs to outputs.
- Latency from input to output is 1 clock:
  - `enable` rising in IDLE → RED on the next edge.
  - `flash` rising → `light`=001 on the next edge.
- Free-running period with no requests: RED_CYC+GRN_CYC+YEL_CYC = 16 clocks (defaults).
- Period with a pedestrian service: 16+PED_CYC = 20 clocks.
- Simultaneous events at RED expiry:
  - `flash` beats everything.
  - A `ped_req` arriving on the expiry clock is serviced in this cycle.
  - `enable`=0 together with a pending request → PED, then GREEN, then the normal cycle until the next RED expiry → IDLE.
- Reset asserted mid-phase: `light`=100 immediately. The next run starts from IDLE.

## Test plan
- Reset: hold `rst_n`=0 for 3 clocks → `light`=100, `ped_ack`=0, `phase`=00, `timer`=0. Drop `rst_n` mid-GREEN, between edges → `light` becomes 100 with no clock edge.
- Free run: `enable`=1 from IDLE → 1 IDLE clock, then 100×8, 010×6, 001×2, repeating with period 16. `timer` counts 7..0, 5..0, 1..0.
- Pedestrian request:
  - 1-clock `ped_req` pulse in GREEN → YELLOW×2, RED×8, PED×4 (`light`=100, `ped_ack`=1), then GREEN.
  - A second pulse during PED → no extra PED in the next cycle.
  - A `ped_req` on the RED expiry clock → PED follows immediately.
- Flash: assert `flash` at GREEN `timer`=3 → next edge 001, then 000, 001, … Deassert after 5 clocks → RED with `timer`=7, then a full 8-clock red. A `ped_req` raised during FLASH → PED after that red.
- Enable drop: `enable`=0 at GREEN `timer`=4 → rest of GREEN, YELLOW×2, RED×8, then IDLE with `light`=100 held. Re-raise `enable` → RED on the next edge.
- Parameter sweep: instantiate with RED_CYC=1, GRN_CYC=1, YEL_CYC=1, PED_CYC=1 → period 3, no stalled or skipped phase. Repeat with RED_CYC=16, CNT_W=4 (full-range timer).
